// File: rtl/render_pkg.sv
// Shared definitions for the render command master: register map, FSM states
// and the packed draw-command layout.
package render_pkg;

    localparam int CMD_W = 32;

    localparam int REG_X    = 1;
    localparam int REG_Y    = 2;
    localparam int REG_CODE = 4;
    localparam int REG_GO   = 6;

    localparam logic [1:0] SLV_CMD    = 2'd0;
    localparam logic [1:0] SLV_STATUS = 2'd1;
    localparam logic [1:0] SLV_CLEAR  = 2'd2;

    localparam int CMD_CODE_LSB    = 0;
    localparam int CMD_X_LSB       = 8;
    localparam int CMD_Y_LSB       = 17;
    localparam int CMD_NOCOORD_BIT = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WR_CODE,
        ST_WR_X,
        ST_WR_Y,
        ST_WR_GO
    } state_e;

    typedef struct packed {
        logic       ign_hi;
        logic       nocoord;
        logic [4:0] ign_mid;
        logic [7:0] y;
        logic [8:0] x;
        logic [7:0] code;
    } cmd_t;

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous command FIFO; head word is presented combinationally on dout_o.
module render_cmd_fifo
    import render_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [CMD_W-1:0]           din_i,
    output logic [CMD_W-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/render_cmd_master.sv
// Command queue plus Avalon-MM master replaying each draw command to render as
// code -> x -> y -> start writes.
//   state    | meaning
//   IDLE     | waiting for a queued command; pops the head into cmd_q
//   LOAD     | cmd_q valid, preparing the code write
//   WR_CODE  | writing code to REG_CODE
//   WR_X     | writing x midpoint to REG_X
//   WR_Y     | writing y midpoint to REG_Y
//   WR_GO    | writing 0 to REG_GO to start the plot
module render_cmd_master
    import render_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        s_address,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    input  logic              s_read,
    output logic [31:0]       s_readdata,
    output logic [AW-1:0]     m_address,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    input  logic              m_waitrequest
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e          state_q;
    cmd_t            cmd_q;
    logic            m_write_q;
    logic [AW-1:0]   m_address_q;
    logic [31:0]     m_writedata_q;
    logic            overflow_q;
    logic [31:0]     s_readdata_q;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [31:0]     fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            wr_cmd;
    logic            accept;
    logic            busy;
    logic [31:0]     status_word;
    logic            unused_cmd_bits;

    assign wr_cmd    = s_write && (s_address == SLV_CMD);
    assign fifo_push = wr_cmd && !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign accept    = m_write_q && !m_waitrequest;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

    assign status_word     = {22'b0, overflow_q, busy, 3'b0, 5'(fifo_count)};
    assign unused_cmd_bits = ^{cmd_q.ign_hi, cmd_q.ign_mid};

    render_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (s_writedata),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Bus outputs are loaded on the transition into each write state so they
    // stay frozen for as long as render holds waitrequest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cmd_q   <= cmd_t'(fifo_dout);
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q       <= ST_WR_CODE;
                    m_write_q     <= 1'b1;
                    m_address_q   <= AW'(REG_CODE);
                    m_writedata_q <= {24'b0, cmd_q.code};
                end
                ST_WR_CODE: begin
                    if (accept) begin
                        if (cmd_q.nocoord) begin
                            state_q       <= ST_WR_GO;
                            m_address_q   <= AW'(REG_GO);
                            m_writedata_q <= '0;
                        end else begin
                            state_q       <= ST_WR_X;
                            m_address_q   <= AW'(REG_X);
                            m_writedata_q <= {23'b0, cmd_q.x};
                        end
                    end
                end
                ST_WR_X: begin
                    if (accept) begin
                        state_q       <= ST_WR_Y;
                        m_address_q   <= AW'(REG_Y);
                        m_writedata_q <= {24'b0, cmd_q.y};
                    end
                end
                ST_WR_Y: begin
                    if (accept) begin
                        state_q       <= ST_WR_GO;
                        m_address_q   <= AW'(REG_GO);
                        m_writedata_q <= '0;
                    end
                end
                ST_WR_GO: begin
                    if (accept) begin
                        state_q       <= ST_IDLE;
                        m_write_q     <= 1'b0;
                        m_address_q   <= '0;
                        m_writedata_q <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    m_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Fullness is sampled before any same-cycle pop, so a push into a full
    // FIFO is always dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q   <= 1'b0;
            s_readdata_q <= '0;
        end else begin
            if (wr_cmd && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (s_write && (s_address == SLV_CLEAR) && s_writedata[0]) begin
                overflow_q <= 1'b0;
            end
            s_readdata_q <= (s_read && (s_address == SLV_STATUS)) ? status_word : '0;
        end
    end

    assign m_write     = m_write_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;
    assign s_readdata  = s_readdata_q;

endmodule
